stepper_decoder: RTL

Monitors the 4-line one-hot phase bus driving a unipolar stepper and reconstructs motion from it: step pulses, direction, a signed position count, lock/error status and a moving indicator. It is the receive end of the stepper phase interface. It sits beside the phase driver, or on a board-level tap of its outputs, for closed-loop checking and position readback. The phase bus is treated as asynchronous to clk.

---
 rtl/stepper_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/stepper_decoder.sv
// Stepper phase-bus receiver.
// Watches the 4-line one-hot phase bus of a unipolar stepper and rebuilds
// step pulses, direction, a signed position count, lock/error status and a
// moving indicator. The phase bus is asynchronous to clk.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   fase   - phase lines, legal codes 0001/0010/0100/1000
//   clr    - synchronous clear of pos and err
//   step   - one-cycle pulse per decoded step
//   dir    - direction of last step (1 = 0001->0010->0100->1000->0001)
//   pos    - signed position, two's complement, wraps modulo 2^POS_W
//   locked - decoder holds a valid reference phase
//   err    - sticky protocol-error flag
//   moving - a step was decoded within the last TIMEOUT cycles
module stepper_decoder #(
   parameter int unsigned POS_W   = 16,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       fase,
   input  logic             clr,
   output logic             step,
   output logic             dir,
   output logic [POS_W-1:0] pos,
   output logic             locked,
   output logic             err,
   output logic             moving
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   state_t             state, state_n;
   logic [3:0]         sync1, sync2;
   logic [3:0]         stored, stored_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               step_n, dir_n, err_n, moving_n;
   logic [POS_W-1:0]   pos_n;
   logic               legal, dec_err, fwd, rev;
   logic [1:0]         delta;

   // One-hot phase code to its index 0..3
   function automatic logic [1:0] ph_idx(input logic [3:0] p);
      return {p[3] | p[2], p[3] | p[1]};
   endfunction

   // Exactly one bit set
   assign legal = (sync2 != 4'b0000) && ((sync2 & (sync2 - 4'd1)) == 4'b0000);
   // Phase advance modulo 4; 2-bit subtraction wraps naturally
   assign delta = ph_idx(sync2) - ph_idx(stored);

   // Next-state and output decode
   always_comb begin
      state_n  = state;
      stored_n = stored;
      step_n   = 1'b0;
      dir_n    = dir;
      pos_n    = pos;
      err_n    = err;
      cnt_n    = cnt;
      moving_n = moving;
      dec_err  = 1'b0;
      fwd      = 1'b0;
      rev      = 1'b0;

      case (state)
         UNLOCKED: begin
            // Idle or startup codes are tolerated while unlocked
            if (legal) begin
               stored_n = sync2;
               state_n  = LOCKED;
            end
         end
         LOCKED: begin
            if (!legal) begin
               dec_err  = 1'b1;
               state_n  = UNLOCKED;
               stored_n = 4'b0000;
            end else begin
               case (delta)
                  2'd1: fwd = 1'b1;
                  2'd3: rev = 1'b1;
                  2'd2: dec_err = 1'b1;
                  default: ;
               endcase
               stored_n = sync2;
            end
         end
         default: state_n = UNLOCKED;
      endcase

      step_n = fwd | rev;
      if (step_n) dir_n = fwd;

      // clr wins over the count; a fresh decode error wins over clr
      if (clr)      pos_n = '0;
      else if (fwd) pos_n = pos + POS_W'(1);
      else if (rev) pos_n = pos - POS_W'(1);

      if (dec_err)  err_n = 1'b1;
      else if (clr) err_n = 1'b0;

      // Stall counter saturates at TIMEOUT, where moving drops
      if (step_n) begin
         cnt_n    = '0;
         moving_n = 1'b1;
      end else begin
         if (cnt < TIMEOUT_C) cnt_n = cnt + CNT_W'(1);
         if (cnt_n >= TIMEOUT_C) moving_n = 1'b0;
      end
   end

   // Synchronizer, state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 4'b0000;
         sync2  <= 4'b0000;
         state  <= UNLOCKED;
         stored <= 4'b0000;
         step   <= 1'b0;
         dir    <= 1'b1;
         pos    <= '0;
         locked <= 1'b0;
         err    <= 1'b0;
         moving <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1  <= fase;
         sync2  <= sync1;
         state  <= state_n;
         stored <= stored_n;
         step   <= step_n;
         dir    <= dir_n;
         pos    <= pos_n;
         locked <= (state_n == LOCKED);
         err    <= err_n;
         moving <= moving_n;
         cnt    <= cnt_n;
      end
   end

endmodule
